// File: rtl/grid_render_pkg.sv
// Purpose : shared constants, derived widths and flash FSM encoding for the grid renderer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package grid_render_pkg;

    // Default geometry; the renderer's parameters take these as defaults.
    localparam int CELL_LOG2_DEF = 4;
    localparam int COLS_DEF      = 10;
    localparam int ROWS_DEF      = 20;

    // Board RAM address widths for the default geometry.
    localparam int ROW_W = $clog2(ROWS_DEF);
    localparam int COL_W = $clog2(COLS_DEF);

    // Colour codes with a fixed meaning.
    localparam int COLOR_EMPTY = 0;
    localparam int COLOR_GRID  = 1;

    // Line-clear flash sequencer states.
    typedef enum logic {
        FS_IDLE  = 1'b0,
        FS_FLASH = 1'b1
    } flash_state_e;

endpackage

// File: rtl/grid_pixel_render_flash_seq.sv
// Purpose : line-clear flash sequencer; blinks the latched rows for FLASH_TOGGLES half-periods.
// Latency : blank_row follows state on the clock after a frame_tick; flash_done is a 1-cycle registered pulse.
// Backpr. : none; flash_start is ignored while a sequence is running.
//
// Ports: clk/rst (async, active-high), frame_tick, flash_start, flash_rows[ROWS-1:0] in;
//        flash_busy, flash_done, blank_row[ROWS-1:0] out.
module flash_seq
    import grid_render_pkg::*;
#(
    parameter int ROWS          = ROWS_DEF,
    parameter int FLASH_PERIOD  = 8,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic            flash_start,
    input  logic [ROWS-1:0] flash_rows,
    output logic            flash_busy,
    output logic            flash_done,
    output logic [ROWS-1:0] blank_row
);

    localparam int TICK_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int TOG_W  = $clog2(FLASH_TOGGLES + 1);

    flash_state_e      state_q, state_d;
    logic [ROWS-1:0]   mask_q, mask_d;
    logic              vis_q, vis_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TOG_W-1:0]  tog_cnt_q, tog_cnt_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        vis_d      = vis_q;
        tick_cnt_d = tick_cnt_q;
        tog_cnt_d  = tog_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            FS_IDLE: begin
                // A frame_tick arriving with the start is deliberately not counted.
                if (flash_start) begin
                    state_d    = FS_FLASH;
                    mask_d     = flash_rows;
                    vis_d      = 1'b1;
                    tick_cnt_d = '0;
                    tog_cnt_d  = '0;
                end
            end
            FS_FLASH: begin
                if (frame_tick) begin
                    if (tick_cnt_q == TICK_W'(FLASH_PERIOD - 1)) begin
                        tick_cnt_d = '0;
                        vis_d      = ~vis_q;
                        tog_cnt_d  = tog_cnt_q + 1'b1;
                        // Even toggle count leaves vis_d = 1, so rows end visible.
                        if (tog_cnt_d == TOG_W'(FLASH_TOGGLES)) begin
                            state_d   = FS_IDLE;
                            mask_d    = '0;
                            tog_cnt_d = '0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            mask_q     <= '0;
            vis_q      <= 1'b1;
            tick_cnt_q <= '0;
            tog_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            vis_q      <= vis_d;
            tick_cnt_q <= tick_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
            done_q     <= done_d;
        end
    end

    assign flash_busy = (state_q == FS_FLASH);
    assign flash_done = done_q;
    assign blank_row  = ((state_q == FS_FLASH) && !vis_q) ? mask_q : '0;

endmodule

// File: rtl/grid_pixel_render.sv
// Purpose : pipelined playfield renderer: cell hit test, board RAM lookup, flash blanking, registered colour.
// Latency : exactly 2 clocks from pix_en to out_valid; one pixel per clock.
// Backpr. : none; pix_en bubbles propagate as out_valid = 0 and other outputs hold.
//
// Ports: clk/rst (async, active-high); pix_en, addr_x/addr_y in; rd_row/rd_col out, rd_data in
//        (sync RAM, 1-cycle read); frame_tick, flash_start, flash_rows in; flash_busy, flash_done out;
//        out_valid, out_in_grid, out_edge, out_inner, out_color out.
// Option : define GRID_PIXEL_LINES_EN to draw empty-cell borders in colour COLOR_GRID.
module grid_pixel_render
    import grid_render_pkg::*;
#(
    parameter int CELL_LOG2     = CELL_LOG2_DEF,
    parameter int COLS          = COLS_DEF,
    parameter int ROWS          = ROWS_DEF,
    parameter int ORG_X         = 240,
    parameter int ORG_Y         = 80,
    parameter int COLOR_W       = 3,
    parameter int FLASH_PERIOD  = 8,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en,
    input  logic [9:0]               addr_x,
    input  logic [9:0]               addr_y,
    output logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [$clog2(COLS)-1:0]  rd_col,
    input  logic [COLOR_W-1:0]       rd_data,
    input  logic                     frame_tick,
    input  logic                     flash_start,
    input  logic [ROWS-1:0]          flash_rows,
    output logic                     flash_busy,
    output logic                     flash_done,
    output logic                     out_valid,
    output logic                     out_in_grid,
    output logic                     out_edge,
    output logic                     out_inner,
    output logic [COLOR_W-1:0]       out_color
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

`ifdef GRID_PIXEL_LINES_EN
    localparam bit LINES_EN = 1'b1;
`else
    localparam bit LINES_EN = 1'b0;
`endif

    // ---------------- stage 0: hit test ----------------
    logic [9:0] dx, dy, cx, cy;
    logic       in_grid0;

    always_comb begin
        // Left/top of origin wraps dx/dy; the >= checks reject those pixels.
        dx       = addr_x - 10'(ORG_X);
        dy       = addr_y - 10'(ORG_Y);
        cx       = dx >> CELL_LOG2;
        cy       = dy >> CELL_LOG2;
        in_grid0 = (addr_x >= 10'(ORG_X)) && (addr_y >= 10'(ORG_Y)) &&
                   (cx < 10'(COLS)) && (cy < 10'(ROWS));
    end

    // Stage-1 registers: RAM address plus in-cell offset metadata.
    logic [RW-1:0]        rd_row_q, rd_row_d;
    logic [CW-1:0]        rd_col_q, rd_col_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_grid_q, s1_grid_d;
    logic [CELL_LOG2-1:0] s1_offx_q, s1_offx_d;
    logic [CELL_LOG2-1:0] s1_offy_q, s1_offy_d;

    // Stage-2 registers: metadata aligned with rd_data.
    logic                 s2_vld_q, s2_vld_d;
    logic                 s2_grid_q, s2_grid_d;
    logic [CELL_LOG2-1:0] s2_offx_q, s2_offx_d;
    logic [CELL_LOG2-1:0] s2_offy_q, s2_offy_d;
    logic [RW-1:0]        s2_row_q, s2_row_d;

    // Output registers.
    logic                 out_valid_q, out_valid_d;
    logic                 out_grid_q, out_grid_d;
    logic                 out_inner_q, out_inner_d;
    logic [COLOR_W-1:0]   out_color_q, out_color_d;

    logic [ROWS-1:0]      blank_row;
    logic                 inner2;
    logic                 blank2;

    flash_seq #(
        .ROWS          (ROWS),
        .FLASH_PERIOD  (FLASH_PERIOD),
        .FLASH_TOGGLES (FLASH_TOGGLES)
    ) u_flash_seq (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .flash_start (flash_start),
        .flash_rows  (flash_rows),
        .flash_busy  (flash_busy),
        .flash_done  (flash_done),
        .blank_row   (blank_row)
    );

    always_comb begin
        // Stage 0 -> 1: capture only on pix_en so idle cycles hold the address.
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        s1_grid_d = s1_grid_q;
        s1_offx_d = s1_offx_q;
        s1_offy_d = s1_offy_q;
        s1_vld_d  = pix_en;
        if (pix_en) begin
            rd_row_d  = in_grid0 ? cy[RW-1:0] : '0;
            rd_col_d  = in_grid0 ? cx[CW-1:0] : '0;
            s1_grid_d = in_grid0;
            s1_offx_d = dx[CELL_LOG2-1:0];
            s1_offy_d = dy[CELL_LOG2-1:0];
        end

        // Stage 1 -> 2: RAM is reading rd_row_q/rd_col_q this cycle.
        s2_vld_d  = s1_vld_q;
        s2_grid_d = s2_grid_q;
        s2_offx_d = s2_offx_q;
        s2_offy_d = s2_offy_q;
        s2_row_d  = s2_row_q;
        if (s1_vld_q) begin
            s2_grid_d = s1_grid_q;
            s2_offx_d = s1_offx_q;
            s2_offy_d = s1_offy_q;
            s2_row_d  = rd_row_q;
        end

        // Stage 2 -> out: rd_data now belongs to the stage-2 pixel.
        inner2 = s2_grid_q &&
                 (s2_offx_q != '0) && (s2_offx_q != '1) &&
                 (s2_offy_q != '0) && (s2_offy_q != '1);
        blank2 = blank_row[s2_row_q];

        out_valid_d = s2_vld_q;
        out_grid_d  = out_grid_q;
        out_inner_d = out_inner_q;
        out_color_d = out_color_q;
        if (s2_vld_q) begin
            out_grid_d  = s2_grid_q;
            out_inner_d = inner2;
            if (!s2_grid_q || blank2) begin
                out_color_d = COLOR_W'(COLOR_EMPTY);
            end else if (LINES_EN && (rd_data == COLOR_W'(COLOR_EMPTY)) && !inner2) begin
                out_color_d = COLOR_W'(COLOR_GRID);
            end else begin
                out_color_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_grid_q   <= 1'b0;
            s1_offx_q   <= '0;
            s1_offy_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_grid_q   <= 1'b0;
            s2_offx_q   <= '0;
            s2_offy_q   <= '0;
            s2_row_q    <= '0;
            out_valid_q <= 1'b0;
            out_grid_q  <= 1'b0;
            out_inner_q <= 1'b0;
            out_color_q <= '0;
        end else begin
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            s1_vld_q    <= s1_vld_d;
            s1_grid_q   <= s1_grid_d;
            s1_offx_q   <= s1_offx_d;
            s1_offy_q   <= s1_offy_d;
            s2_vld_q    <= s2_vld_d;
            s2_grid_q   <= s2_grid_d;
            s2_offx_q   <= s2_offx_d;
            s2_offy_q   <= s2_offy_d;
            s2_row_q    <= s2_row_d;
            out_valid_q <= out_valid_d;
            out_grid_q  <= out_grid_d;
            out_inner_q <= out_inner_d;
            out_color_q <= out_color_d;
        end
    end

    assign rd_row      = rd_row_q;
    assign rd_col      = rd_col_q;
    assign out_valid   = out_valid_q;
    assign out_in_grid = out_grid_q;
    assign out_edge    = out_grid_q;
    assign out_inner   = out_inner_q;
    assign out_color   = out_color_q;

endmodule

// File: tb/tb_grid_pixel_render.sv
// Purpose : directed self-checking bench for grid_pixel_render with a 1-cycle board RAM model.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpr. : n/a.
module tb_grid_pixel_render;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic [9:0]  addr_x;
    logic [9:0]  addr_y;
    logic [4:0]  rd_row;
    logic [3:0]  rd_col;
    logic [2:0]  rd_data;
    logic        frame_tick;
    logic        flash_start;
    logic [19:0] flash_rows;
    logic        flash_busy;
    logic        flash_done;
    logic        out_valid;
    logic        out_in_grid;
    logic        out_edge;
    logic        out_inner;
    logic [2:0]  out_color;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;

`ifdef GRID_PIXEL_LINES_EN
    localparam int LINE_C = 1;
`else
    localparam int LINE_C = 0;
`endif

    logic [2:0] board [0:19][0:9];

    grid_pixel_render dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .addr_x      (addr_x),
        .addr_y      (addr_y),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .frame_tick  (frame_tick),
        .flash_start (flash_start),
        .flash_rows  (flash_rows),
        .flash_busy  (flash_busy),
        .flash_done  (flash_done),
        .out_valid   (out_valid),
        .out_in_grid (out_in_grid),
        .out_edge    (out_edge),
        .out_inner   (out_inner),
        .out_color   (out_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous board RAM, 1-cycle read latency.
    always @(posedge clk)
        rd_data <= (rd_row < 5'd20 && rd_col < 4'd10) ? board[rd_row][rd_col] : 3'd0;

    always @(negedge clk)
        if (flash_done) done_cnt = done_cnt + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One isolated pixel: address checked one edge later, outputs two edges later.
    task automatic pix_chk(input string tag, input int x, input int y,
                           input int e_row, input int e_col, input int e_grid,
                           input int e_inner, input int e_color);
        @(negedge clk);
        pix_en = 1'b1;
        addr_x = 10'(x);
        addr_y = 10'(y);
        @(negedge clk);
        pix_en = 1'b0;
        chk({tag, ".rd_row"}, int'(rd_row), e_row);
        chk({tag, ".rd_col"}, int'(rd_col), e_col);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".in_grid"}, int'(out_in_grid), e_grid);
        chk({tag, ".edge"}, int'(out_edge), e_grid);
        chk({tag, ".inner"}, int'(out_inner), e_inner);
        chk({tag, ".color"}, int'(out_color), e_color);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                board[r][c] = 3'd0;
        board[2][3] = 3'd5;
        board[5][3] = 3'd6;

        rst = 1'b1; pix_en = 1'b0; addr_x = '0; addr_y = '0;
        frame_tick = 1'b0; flash_start = 1'b0; flash_rows = '0;
        repeat (3) @(negedge clk);
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.color", int'(out_color), 0);
        chk("rst.rd_row", int'(rd_row), 0);
        chk("rst.busy", int'(flash_busy), 0);
        chk("rst.done", int'(flash_done), 0);
        rst = 1'b0;

        // Cell (row 2, col 3) interior, offsets (4,4).
        pix_chk("hit", 292, 116, 2, 3, 1, 1, 5);
        // Borders of the same cell.
        pix_chk("brd_x0", 288, 116, 2, 3, 1, 0, 5);
        pix_chk("brd_x15", 303, 116, 2, 3, 1, 0, 5);
        pix_chk("brd_y15", 292, 127, 2, 3, 1, 0, 5);
        // Out of grid on each side.
        pix_chk("oog_left", 239, 116, 0, 0, 0, 0, 0);
        pix_chk("oog_right", 400, 116, 0, 0, 0, 0, 0);
        pix_chk("oog_bottom", 292, 400, 0, 0, 0, 0, 0);
        // Last pixel of the last cell (empty, border).
        pix_chk("last", 399, 399, 19, 9, 1, 0, LINE_C);

        // Back-to-back: row 2 then row 5, then bubble.
        @(negedge clk); pix_en = 1'b1; addr_x = 10'd292; addr_y = 10'd116;
        @(negedge clk); addr_y = 10'd164;
        @(negedge clk); pix_en = 1'b0;
        @(negedge clk);
        chk("b2b.a.valid", int'(out_valid), 1);
        chk("b2b.a.color", int'(out_color), 5);
        @(negedge clk);
        chk("b2b.b.valid", int'(out_valid), 1);
        chk("b2b.b.color", int'(out_color), 6);
        @(negedge clk);
        chk("b2b.bubble.valid", int'(out_valid), 0);
        chk("b2b.hold.color", int'(out_color), 6);

        // Flash row 2; start coincides with a frame_tick which must not count.
        done_base = done_cnt;
        @(negedge clk); flash_rows = 20'h4; flash_start = 1'b1; frame_tick = 1'b1;
        @(negedge clk); flash_start = 1'b0; frame_tick = 1'b0;
        chk("fl.busy", int'(flash_busy), 1);
        pix_chk("fl.vis", 292, 116, 2, 3, 1, 1, 5);
        ticks(8);
        pix_chk("fl.blank", 292, 116, 2, 3, 1, 1, 0);
        pix_chk("fl.other", 292, 164, 5, 3, 1, 1, 6);
        ticks(12);
        // Second start mid-sequence (row 5) must be ignored.
        @(negedge clk); flash_rows = 20'h20; flash_start = 1'b1;
        @(negedge clk); flash_start = 1'b0;
        ticks(27);
        chk("fl.47.busy", int'(flash_busy), 1);
        chk("fl.47.nodone", done_cnt - done_base, 0);
        pix_chk("fl.47.blank", 292, 116, 2, 3, 1, 1, 0);
        pix_chk("fl.47.row5", 292, 164, 5, 3, 1, 1, 6);
        ticks(1);
        chk("fl.48.done", int'(flash_done), 1);
        @(negedge clk);
        chk("fl.48.pulse", int'(flash_done), 0);
        chk("fl.48.busy", int'(flash_busy), 0);
        @(negedge clk);
        chk("fl.48.count", done_cnt - done_base, 1);
        pix_chk("fl.after", 292, 116, 2, 3, 1, 1, 5);

        // Reset mid-flash with a full pipeline.
        @(negedge clk); flash_rows = 20'h4; flash_start = 1'b1;
        @(negedge clk); flash_start = 1'b0;
        ticks(20);
        chk("rm.busy", int'(flash_busy), 1);
        @(negedge clk); pix_en = 1'b1; addr_x = 10'd292; addr_y = 10'd116;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rm.pre.valid", int'(out_valid), 1);
        done_base = done_cnt;
        rst = 1'b1;
        #1;
        chk("rm.busy0", int'(flash_busy), 0);
        chk("rm.valid0", int'(out_valid), 0);
        chk("rm.rd_row0", int'(rd_row), 0);
        pix_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        ticks(40);
        chk("rm.nodone", done_cnt - done_base, 0);
        chk("rm.idle", int'(flash_busy), 0);
        pix_chk("rm.after", 292, 116, 2, 3, 1, 1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grid_pixel_render.md
Name: grid_pixel_render

Overview:
- Pipelined renderer for the whole Tetris playfield. Generalises the single-cell hit test into a COLS x ROWS grid with parametrised cell size, origin and colour width.
- Per pixel: computes the cell index and inner/edge flags, reads the cell colour from the board RAM, and emits a registered colour.
- Contains the line-clear flash sequencer: selected rows blink for a fixed number of frames.
- Sits between the VGA timing generator and the final colour mux.

Parameters:
- CELL_LOG2, 4, log2 of cell edge in pixels (cell size = 2^CELL_LOG2).
- COLS, 10, grid columns.
- ROWS, 20, grid rows.
- ORG_X, 240, x pixel of the grid's upper-left corner.
- ORG_Y, 80, y pixel of the grid's upper-left corner.
- COLOR_W, 3, board colour code width; code 0 means empty.
- FLASH_PERIOD, 8, frame_ticks per visibility toggle.
- FLASH_TOGGLES, 6, number of toggles before done (even value, so rows end visible).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- pix_en  in  1  pixel strobe; addr sampled when high.
- addr_x  in  10  current pixel x.
- addr_y  in  10  current pixel y.
- rd_row  out  clog2(ROWS)  board RAM row address.
- rd_col  out  clog2(COLS)  board RAM column address.
- rd_data  in  COLOR_W  board RAM data; synchronous, 1-cycle read latency.
- frame_tick  in  1  one-cycle pulse per frame.
- flash_start  in  1  start the flash sequence.
- flash_rows  in  ROWS  rows to flash; bit r = row r.
- flash_busy  out  1  high while the sequence runs.
- flash_done  out  1  one-cycle pulse when the sequence ends.
- out_valid  out  1  output pixel valid.
- out_in_grid  out  1  pixel lies inside the grid.
- out_edge  out  1  pixel inside a cell, including its border.
- out_inner  out  1  pixel inside a cell, excluding its 1-pixel border.
- out_color  out  COLOR_W  rendered colour code.

Behaviour:
- Reset: all outputs 0; FSM IDLE; latched mask 0; vis = 1; counters 0.
- Stage 0 (edge N, pix_en = 1):
  - dx = addr_x - ORG_X and dy = addr_y - ORG_Y, computed at 10 bits.
  - in_grid = addr_x >= ORG_X && addr_y >= ORG_Y && dx>>CELL_LOG2 < COLS && dy>>CELL_LOG2 < ROWS.
  - rd_col = dx>>CELL_LOG2 and rd_row = dy>>CELL_LOG2, registered. Both forced 0 when !in_grid.
  - Low CELL_LOG2 bits of dx/dy are registered as the in-cell offset, alongside in_grid.
- Stage 1 (edge N+1): rd_data valid; metadata delayed one cycle.
- Stage 2 (edge N+2) outputs registered:
  - out_valid = 1, i.e. latency exactly 2 clocks.
  - out_edge = in_grid.
  - out_inner = in_grid && both offsets in 1 .. 2^CELL_LOG2 - 2.
  - out_color = rd_data, or 0 if !in_grid or the row is blanked.
- pix_en = 0: the bubble propagates and out_valid = 0 two cycles later. Other outputs hold their last values.
- Back-to-back pix_en: one pixel accepted per clock, no stalls.
- Flash FSM:
  - IDLE: flash_start latches flash_rows, clears counters, sets vis = 1 → FLASH.
  - FLASH: flash_busy = 1. Each frame_tick increments tick_cnt. When tick_cnt reaches FLASH_PERIOD-1: vis toggles, tick_cnt resets to 0, tog_cnt increments. When tog_cnt reaches FLASH_TOGGLES: flash_done pulses, mask clears → IDLE.
  - Row r is blanked when FLASH && mask[r] && vis == 0. Blanked rows render out_color = 0; geometry flags are unaffected.
  - flash_start while FLASH: ignored.
  - flash_start and frame_tick in the same IDLE cycle: start taken, tick not counted.
  - Blanking is evaluated at stage 2 using the stage-2 row.
- Reset mid-flash: immediate return to IDLE, no flash_done pulse, pipeline flushed (out_valid = 0).

Optional Feature:
- Macro GRID_PIXEL_LINES_EN.
- Defined: empty cells (rd_data = 0, in_grid, not inner) output colour code 1 as grid lines. Blanked rows still output 0.
- Undefined: empty cells output 0 everywhere.

Decomposition:
- Package grid_render_pkg holds: CELL_LOG2 default, ROW_W/COL_W derived widths, the COLOR_EMPTY = 0 and COLOR_GRID = 1 constants, and the flash FSM state encoding.
- One sub-module, flash_seq, holds the flash FSM, counters and mask. It outputs a blank_row[ROWS-1:0] vector to the pipeline.

Test Plan:
- Pixel pipeline:
  - Stimulus: reset; board cell (2,3) = 5; pix_en with (x,y) = (240+3·16+4, 80+2·16+4).
  - Required response: rd_row = 2 and rd_col = 3 after one edge; two edges later out_valid = 1, out_color = 5, out_inner = 1, out_edge = 1.
- Cell border:
  - Stimulus: x = 240+3·16 (offset 0), same row.
  - Required response: out_edge = 1, out_inner = 0; x offset 15 gives the same result.
- Out of grid:
  - Stimulus: x = 239; then x = 240+160; then y = 80+320.
  - Required response: out_in_grid = 0, out_color = 0, rd_row = rd_col = 0 for each.
- Flash sequence:
  - Stimulus: flash_rows bit 2 set, flash_start, then FLASH_PERIOD = 8 frame_ticks.
  - Required response: row-2 pixels render 0, other rows are unaffected. After 48 ticks total, flash_done pulses once, flash_busy falls, and row 2 renders 5.
- Simultaneous and repeated events:
  - flash_start together with frame_tick → the tick is not counted (done arrives after 48 further ticks).
  - Second flash_start mid-sequence → ignored.
- Reset mid-flash:
  - Stimulus: assert rst after 20 ticks.
  - Required response: flash_busy = 0 and out_valid = 0 immediately; no flash_done; row 2 renders normally afterwards.
